// File: rtl/issue_scheduler.sv
// Issue scheduler: per-row operand readiness for 16 RS rows and one registered issue pick per FU.
// Define SCHED_OLDEST_FIRST_EN for oldest-ROB-first selection instead of per-FU round-robin.
module issue_scheduler #(
    parameter int RS_DEPTH = 16,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 4,
    parameter int NUM_FU   = 3,
    parameter int LINE_W   = $clog2(RS_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid_1,
    input  logic                     disp_valid_2,
    input  logic [LINE_W-1:0]        disp_line_1,
    input  logic [LINE_W-1:0]        disp_line_2,
    input  logic [1:0]               disp_fu_1,
    input  logic [1:0]               disp_fu_2,
    input  logic [PREG_W-1:0]        disp_ps1_1,
    input  logic [PREG_W-1:0]        disp_ps2_1,
    input  logic [PREG_W-1:0]        disp_ps1_2,
    input  logic [PREG_W-1:0]        disp_ps2_2,
    input  logic                     disp_rdy1_1,
    input  logic                     disp_rdy2_1,
    input  logic                     disp_rdy1_2,
    input  logic                     disp_rdy2_2,
    input  logic [ROB_W-1:0]         disp_rob_1,
    input  logic [ROB_W-1:0]         disp_rob_2,
    input  logic [NUM_FU-1:0]        cdb_valid,
    input  logic [NUM_FU*PREG_W-1:0] cdb_tag,
    input  logic [ROB_W-1:0]         rob_head,
    output logic [NUM_FU-1:0]        issue_valid,
    output logic [NUM_FU*LINE_W-1:0] issue_line,
    input  logic [NUM_FU-1:0]        issue_ready,
    output logic [RS_DEPTH-1:0]      rs_busy,
    output logic                     disp_ready,
    output logic                     err_dup
);

    logic [RS_DEPTH-1:0] busy, r1, r2, held;
    logic [1:0]          fu_q  [RS_DEPTH];
    logic [PREG_W-1:0]   ps1_q [RS_DEPTH];
    logic [PREG_W-1:0]   ps2_q [RS_DEPTH];
    logic [ROB_W-1:0]    rob_q [RS_DEPTH];

    logic [NUM_FU-1:0]   valid_q;
    logic [LINE_W-1:0]   line_q   [NUM_FU];
    logic [NUM_FU-1:0]   take, fire, sel_found;
    logic [LINE_W-1:0]   sel_line [NUM_FU];
    logic [RS_DEPTH-1:0] elig     [NUM_FU];
    logic                dup1, dup2, same_line, wr1, wr2;

    // Tag 0 is the hardwired-ready register and never counts as a broadcast match.
    function automatic logic woken(input logic [PREG_W-1:0] tag,
                                   input logic [NUM_FU-1:0] cv,
                                   input logic [NUM_FU*PREG_W-1:0] ct);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_FU; k++)
            if (cv[k] && ct[k*PREG_W +: PREG_W] == tag)
                hit = 1'b1;
        return hit && (tag != '0);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_FU; k++)
            for (int i = 0; i < RS_DEPTH; i++)
                elig[k][i] = busy[i] & r1[i] & r2[i] & ~held[i] & (fu_q[i] == 2'(k));
    end

    assign take = ~valid_q | issue_ready;
    assign fire = valid_q & issue_ready;

    always_comb begin
        same_line = disp_valid_1 && disp_valid_2 && (disp_line_1 == disp_line_2);
        dup1      = disp_valid_1 && (busy[disp_line_1] || disp_fu_1 == 2'd3);
        dup2      = disp_valid_2 && (busy[disp_line_2] || disp_fu_2 == 2'd3 || same_line);
        wr1       = disp_valid_1 && !dup1;
        wr2       = disp_valid_2 && !dup2;
    end

`ifdef SCHED_OLDEST_FIRST_EN
    always_comb begin
        logic [ROB_W-1:0] age, best;
        age = '0;
        best = '1;
        for (int k = 0; k < NUM_FU; k++) begin
            sel_found[k] = 1'b0;
            sel_line[k]  = '0;
            best         = '1;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age = rob_q[i] - rob_head;
                if (elig[k][i] && (!sel_found[k] || age < best)) begin
                    sel_found[k] = 1'b1;
                    sel_line[k]  = LINE_W'(i);
                    best         = age;
                end
            end
        end
    end
`else
    logic [LINE_W-1:0] rr_ptr [NUM_FU];
    logic              unused_rob;

    // Search order starts just past the last grant; offset RS_DEPTH wraps back to rr_ptr itself.
    always_comb begin
        logic [LINE_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sel_found[k] = 1'b0;
            sel_line[k]  = '0;
            for (int off = 1; off <= RS_DEPTH; off++) begin
                idx = rr_ptr[k] + LINE_W'(off);
                if (!sel_found[k] && elig[k][idx]) begin
                    sel_found[k] = 1'b1;
                    sel_line[k]  = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FU; k++) rr_ptr[k] <= '1;
        end else if (flush) begin
            for (int k = 0; k < NUM_FU; k++) rr_ptr[k] <= '1;
        end else begin
            for (int k = 0; k < NUM_FU; k++)
                if (take[k] && sel_found[k]) rr_ptr[k] <= sel_line[k];
        end
    end

    always_comb begin
        unused_rob = ^rob_head;
        for (int i = 0; i < RS_DEPTH; i++) unused_rob = unused_rob ^ (^rob_q[i]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            r1   <= '0;
            r2   <= '0;
            held <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                fu_q[i]  <= '0;
                ps1_q[i] <= '0;
                ps2_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else if (flush) begin
            busy <= '0;
            r1   <= '0;
            r2   <= '0;
            held <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i] && woken(ps1_q[i], cdb_valid, cdb_tag)) r1[i] <= 1'b1;
                if (busy[i] && woken(ps2_q[i], cdb_valid, cdb_tag)) r2[i] <= 1'b1;
            end
            // The accepted row is held, so it can never be the row loaded on the same edge.
            for (int k = 0; k < NUM_FU; k++) begin
                if (fire[k]) begin
                    busy[line_q[k]] <= 1'b0;
                    held[line_q[k]] <= 1'b0;
                end
                if (take[k] && sel_found[k]) held[sel_line[k]] <= 1'b1;
            end
            if (wr1) begin
                busy[disp_line_1]  <= 1'b1;
                held[disp_line_1]  <= 1'b0;
                fu_q[disp_line_1]  <= disp_fu_1;
                ps1_q[disp_line_1] <= disp_ps1_1;
                ps2_q[disp_line_1] <= disp_ps2_1;
                rob_q[disp_line_1] <= disp_rob_1;
                r1[disp_line_1]    <= disp_rdy1_1 || disp_ps1_1 == '0 || woken(disp_ps1_1, cdb_valid, cdb_tag);
                r2[disp_line_1]    <= disp_rdy2_1 || disp_ps2_1 == '0 || woken(disp_ps2_1, cdb_valid, cdb_tag);
            end
            if (wr2) begin
                busy[disp_line_2]  <= 1'b1;
                held[disp_line_2]  <= 1'b0;
                fu_q[disp_line_2]  <= disp_fu_2;
                ps1_q[disp_line_2] <= disp_ps1_2;
                ps2_q[disp_line_2] <= disp_ps2_2;
                rob_q[disp_line_2] <= disp_rob_2;
                r1[disp_line_2]    <= disp_rdy1_2 || disp_ps1_2 == '0 || woken(disp_ps1_2, cdb_valid, cdb_tag);
                r2[disp_line_2]    <= disp_rdy2_2 || disp_ps2_2 == '0 || woken(disp_ps2_2, cdb_valid, cdb_tag);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_FU; k++) line_q[k] <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (take[k]) begin
                    valid_q[k] <= sel_found[k];
                    if (sel_found[k]) line_q[k] <= sel_line[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_dup <= 1'b0;
        else if (!flush && (dup1 || dup2))
            err_dup <= 1'b1;
    end

    always_comb begin
        issue_line = '0;
        for (int k = 0; k < NUM_FU; k++) issue_line[k*LINE_W +: LINE_W] = line_q[k];
    end

    assign issue_valid = valid_q;
    assign rs_busy     = busy;
    assign disp_ready  = ($countones(~busy) >= 2);

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios then random traffic, all checked against a row-table model.
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        disp_valid_1, disp_valid_2;
    logic [3:0]  disp_line_1, disp_line_2;
    logic [1:0]  disp_fu_1, disp_fu_2;
    logic [5:0]  disp_ps1_1, disp_ps2_1, disp_ps1_2, disp_ps2_2;
    logic        disp_rdy1_1, disp_rdy2_1, disp_rdy1_2, disp_rdy2_2;
    logic [3:0]  disp_rob_1, disp_rob_2;
    logic [2:0]  cdb_valid;
    logic [17:0] cdb_tag;
    logic [3:0]  rob_head;
    logic [2:0]  issue_valid;
    logic [11:0] issue_line;
    logic [2:0]  issue_ready;
    logic [15:0] rs_busy;
    logic        disp_ready, err_dup;

    int n_checks = 0;
    int n_err    = 0;

    issue_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid_1(disp_valid_1), .disp_valid_2(disp_valid_2),
        .disp_line_1(disp_line_1), .disp_line_2(disp_line_2),
        .disp_fu_1(disp_fu_1), .disp_fu_2(disp_fu_2),
        .disp_ps1_1(disp_ps1_1), .disp_ps2_1(disp_ps2_1),
        .disp_ps1_2(disp_ps1_2), .disp_ps2_2(disp_ps2_2),
        .disp_rdy1_1(disp_rdy1_1), .disp_rdy2_1(disp_rdy2_1),
        .disp_rdy1_2(disp_rdy1_2), .disp_rdy2_2(disp_rdy2_2),
        .disp_rob_1(disp_rob_1), .disp_rob_2(disp_rob_2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rob_head(rob_head),
        .issue_valid(issue_valid), .issue_line(issue_line), .issue_ready(issue_ready),
        .rs_busy(rs_busy), .disp_ready(disp_ready), .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy; int fu; int ps1; int ps2; bit r1; bit r2; int rob; bit held;
    } row_t;

    row_t m[16];
    bit   m_iv[3];
    int   m_il[3];
    int   m_rr[3];
    bit   m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit can_issue(int c, int k);
        return m[c].busy && m[c].r1 && m[c].r2 && !m[c].held && m[c].fu == k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = '{default: 0};
        for (int k = 0; k < 3; k++) begin m_iv[k] = 0; m_il[k] = 0; m_rr[k] = 15; end
        m_err = 0;
    endtask

    // Next state from the current table and the inputs present before the edge.
    task automatic model_step();
        row_t nx[16];
        bit   woke[64];
        bit   ok1, ok2;
        int   l1, l2, pick, best, age;
        if (flush) begin
            for (int i = 0; i < 16; i++) m[i] = '{default: 0};
            for (int k = 0; k < 3; k++) begin m_iv[k] = 0; m_rr[k] = 15; end
            return;
        end
        for (int t = 0; t < 64; t++) woke[t] = 0;
        for (int k = 0; k < 3; k++)
            if (cdb_valid[k] && cdb_tag[k*6 +: 6] != 0) woke[cdb_tag[k*6 +: 6]] = 1;
        nx = m;
        for (int i = 0; i < 16; i++)
            if (m[i].busy) begin
                if (woke[m[i].ps1]) nx[i].r1 = 1;
                if (woke[m[i].ps2]) nx[i].r2 = 1;
            end
        for (int k = 0; k < 3; k++) begin
            if (m_iv[k] && issue_ready[k]) begin
                nx[m_il[k]].busy = 0;
                nx[m_il[k]].held = 0;
            end
            if (!m_iv[k] || issue_ready[k]) begin
                pick = -1;
`ifdef SCHED_OLDEST_FIRST_EN
                best = 99;
                for (int c = 0; c < 16; c++) begin
                    age = (m[c].rob - int'(rob_head) + 16) % 16;
                    if (can_issue(c, k) && age < best) begin best = age; pick = c; end
                end
`else
                for (int j = 1; j <= 16; j++)
                    if (pick < 0 && can_issue((m_rr[k] + j) % 16, k)) pick = (m_rr[k] + j) % 16;
`endif
                if (pick >= 0) begin
                    m_iv[k] = 1; m_il[k] = pick; m_rr[k] = pick; nx[pick].held = 1;
                end else begin
                    m_iv[k] = 0;
                end
            end
        end
        l1 = int'(disp_line_1);
        l2 = int'(disp_line_2);
        ok1 = disp_valid_1 && !m[l1].busy && disp_fu_1 != 3;
        ok2 = disp_valid_2 && !m[l2].busy && disp_fu_2 != 3 && !(disp_valid_1 && l1 == l2);
        if ((disp_valid_1 && !ok1) || (disp_valid_2 && !ok2)) m_err = 1;
        if (ok1) begin
            nx[l1].busy = 1; nx[l1].held = 0; nx[l1].fu = int'(disp_fu_1);
            nx[l1].ps1 = int'(disp_ps1_1); nx[l1].ps2 = int'(disp_ps2_1); nx[l1].rob = int'(disp_rob_1);
            nx[l1].r1 = disp_rdy1_1 || disp_ps1_1 == 0 || woke[disp_ps1_1];
            nx[l1].r2 = disp_rdy2_1 || disp_ps2_1 == 0 || woke[disp_ps2_1];
        end
        if (ok2) begin
            nx[l2].busy = 1; nx[l2].held = 0; nx[l2].fu = int'(disp_fu_2);
            nx[l2].ps1 = int'(disp_ps1_2); nx[l2].ps2 = int'(disp_ps2_2); nx[l2].rob = int'(disp_rob_2);
            nx[l2].r1 = disp_rdy1_2 || disp_ps1_2 == 0 || woke[disp_ps1_2];
            nx[l2].r2 = disp_rdy2_2 || disp_ps2_2 == 0 || woke[disp_ps2_2];
        end
        m = nx;
    endtask

    task automatic compare_all();
        logic [2:0]  ev;
        logic [15:0] eb;
        int          nfree;
        nfree = 0;
        for (int k = 0; k < 3; k++) ev[k] = m_iv[k];
        for (int i = 0; i < 16; i++) begin
            eb[i] = m[i].busy;
            if (!m[i].busy) nfree++;
        end
        chk("issue_valid", 32'(issue_valid), 32'(ev));
        for (int k = 0; k < 3; k++)
            if (m_iv[k]) chk($sformatf("issue_line%0d", k), 32'(issue_line[k*4 +: 4]), 32'(m_il[k]));
        chk("rs_busy", 32'(rs_busy), 32'(eb));
        chk("disp_ready", 32'(disp_ready), 32'(nfree >= 2));
        chk("err_dup", 32'(err_dup), 32'(m_err));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clr_inputs();
        flush = 0; disp_valid_1 = 0; disp_valid_2 = 0;
        cdb_valid = 0; cdb_tag = 0;
    endtask

    task automatic disp1(input int line, input int fu, input int p1, input int p2,
                         input bit r1, input bit r2, input int rob);
        disp_valid_1 = 1; disp_line_1 = 4'(line); disp_fu_1 = 2'(fu);
        disp_ps1_1 = 6'(p1); disp_ps2_1 = 6'(p2); disp_rdy1_1 = r1; disp_rdy2_1 = r2; disp_rob_1 = 4'(rob);
    endtask

    task automatic disp2(input int line, input int fu, input int p1, input int p2,
                         input bit r1, input bit r2, input int rob);
        disp_valid_2 = 1; disp_line_2 = 4'(line); disp_fu_2 = 2'(fu);
        disp_ps1_2 = 6'(p1); disp_ps2_2 = 6'(p2); disp_rdy1_2 = r1; disp_rdy2_2 = r2; disp_rob_2 = 4'(rob);
    endtask

    function automatic int pick_line();
        int q[$];
        for (int i = 0; i < 16; i++) if (!m[i].busy) q.push_back(i);
        if (q.size() == 0 || $urandom_range(0, 9) == 0) return int'($urandom_range(0, 15));
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    task automatic rand_inputs();
        int l1, l2;
        clr_inputs();
        flush = ($urandom_range(0, 63) == 0);
        l1 = pick_line();
        l2 = ($urandom_range(0, 15) == 0) ? l1 : pick_line();
        if ($urandom_range(0, 1) == 1)
            disp1(l1, ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, (l1 * 7 + 3) % 16);
        if ($urandom_range(0, 1) == 1)
            disp2(l2, ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, (l2 * 7 + 3) % 16);
        cdb_valid   = 3'($urandom_range(0, 7));
        cdb_tag     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
        issue_ready = 3'($urandom_range(0, 7));
        rob_head    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int waited;
        rst_n = 1;
        clr_inputs();
        disp1(0, 0, 0, 0, 0, 0, 0); disp2(0, 0, 0, 0, 0, 0, 0);
        disp_valid_1 = 0; disp_valid_2 = 0;
        issue_ready = 0; rob_head = 0;
        #1 rst_n = 0;
        model_reset();
        #10;
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("reset_issue_line", 32'(issue_line), 32'd0);
        chk("reset_rs_busy", 32'(rs_busy), 32'd0);
        chk("reset_err_dup", 32'(err_dup), 32'd0);
        chk("reset_disp_ready", 32'(disp_ready), 32'd1);
        rst_n = 1;

        // Wakeup via CDB on FU1's lane, then handshake frees the row.
        disp1(3, 0, 5, 0, 0, 0, 3);
        cycle(); clr_inputs();
        chk("t1_no_issue", 32'(issue_valid[0]), 32'd0);
        cycle();
        cdb_valid = 3'b010; cdb_tag[6 +: 6] = 6'd5;
        cycle(); clr_inputs();
        chk("t1_woken_not_yet", 32'(issue_valid[0]), 32'd0);
        cycle();
        chk("t1_issue_valid", 32'(issue_valid[0]), 32'd1);
        chk("t1_issue_line", 32'(issue_line[3:0]), 32'd3);
        issue_ready[0] = 1;
        cycle();
        chk("t1_freed", 32'(rs_busy[3]), 32'd0);

        // Backpressure hold, then back-to-back on the memory unit.
        issue_ready[2] = 0;
        disp1(2, 2, 0, 0, 1, 1, 2); disp2(7, 2, 0, 0, 1, 1, 7);
        cycle(); clr_inputs();
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("t2_hold_line", 32'(issue_line[11:8]), 32'd2);
        end
        issue_ready[2] = 1;
        cycle();
        chk("t2_b2b_line", 32'(issue_line[11:8]), 32'd7);
        chk("t2_b2b_valid", 32'(issue_valid[2]), 32'd1);
        cycle();
        chk("t2_drained", 32'(issue_valid[2]), 32'd0);

        // Same-cycle wakeup at dispatch.
        disp1(4, 0, 9, 0, 0, 0, 4);
        cdb_valid = 3'b001; cdb_tag[5:0] = 6'd9;
        cycle(); clr_inputs();
        chk("t3_edge1", 32'(issue_valid[0]), 32'd0);
        cycle();
        chk("t3_edge2", 32'(issue_valid[0]), 32'd1);
        chk("t3_line", 32'(issue_line[3:0]), 32'd4);
        cycle(); cycle();

        // Fill 15 rows with never-ready sources, then hit a busy row.
        for (int l = 0; l < 15; l += 2) begin
            disp1(l, 0, 60, 0, 0, 0, l);
            if (l + 1 < 15) disp2(l + 1, 0, 60, 0, 0, 0, l + 1);
            cycle(); clr_inputs();
        end
        chk("t4_disp_ready", 32'(disp_ready), 32'd0);
        chk("t4_err_before", 32'(err_dup), 32'd0);
        disp1(6, 1, 0, 0, 1, 1, 6);
        cycle(); clr_inputs();
        chk("t4_err_dup", 32'(err_dup), 32'd1);
        cycle(); cycle();
        chk("t4_row6_kept", 32'(issue_valid[1]), 32'd0);

        // Flush with every FU presenting and a dispatch in the same cycle.
        flush = 1;
        cycle(); clr_inputs();
        issue_ready = 0;
        disp1(1, 0, 0, 0, 1, 1, 1); disp2(2, 1, 0, 0, 1, 1, 2);
        cycle(); clr_inputs();
        disp1(3, 2, 0, 0, 1, 1, 3);
        cycle(); clr_inputs();
        waited = 0;
        while (issue_valid != 3'b111 && waited < 10) begin cycle(); waited++; end
        chk("t5_all_valid", 32'(issue_valid), 32'd7);
        flush = 1; disp1(9, 0, 0, 0, 1, 1, 9);
        cycle(); clr_inputs();
        chk("t5_busy_clear", 32'(rs_busy), 32'd0);
        chk("t5_valid_clear", 32'(issue_valid), 32'd0);

        // Selection order between two ready FU1 rows.
        rob_head = 14;
        disp1(0, 1, 0, 0, 1, 1, 1); disp2(5, 1, 0, 0, 1, 1, 15);
        cycle(); clr_inputs();
        cycle();
`ifdef SCHED_OLDEST_FIRST_EN
        chk("t6_first_line", 32'(issue_line[7:4]), 32'd5);
`else
        chk("t6_first_line", 32'(issue_line[7:4]), 32'd0);
`endif
        issue_ready = 3'b111;
        cycle(); cycle();

        for (int n = 0; n < 800; n++) begin
            rand_inputs();
            cycle();
        end

        clr_inputs();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
